// File: rtl/mem_port_arbiter_if.sv
// Core-side and memory-side handshake bundle for mem_port_arbiter.
// The slave modport is the arbiter; master is the environment (core plus memory).
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              imem_rd_en_i;
    logic [ADDR_W-1:0] imem_addr_i;
    logic              imem_busy_o;
    logic              imem_rdy_o;
    logic [31:0]       imem_rd_data_o;

    logic              dmem_rd_en_i;
    logic              dmem_wr_en_i;
    logic [ADDR_W-1:0] dmem_addr_i;
    logic [1:0]        dmem_wr_size_i;
    logic [31:0]       dmem_wr_data_i;
    logic              dmem_busy_o;
    logic              dmem_rdy_o;
    logic [31:0]       dmem_rd_data_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [1:0]        mem_size_o;
    logic [31:0]       mem_wr_data_o;
    logic              mem_busy_i;
    logic              mem_rdy_i;
    logic [31:0]       mem_rd_data_i;

    modport slave (
        input  imem_rd_en_i, imem_addr_i,
        output imem_busy_o, imem_rdy_o, imem_rd_data_o,
        input  dmem_rd_en_i, dmem_wr_en_i, dmem_addr_i, dmem_wr_size_i, dmem_wr_data_i,
        output dmem_busy_o, dmem_rdy_o, dmem_rd_data_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_size_o, mem_wr_data_o,
        input  mem_busy_i, mem_rdy_i, mem_rd_data_i
    );

    modport master (
        output imem_rd_en_i, imem_addr_i,
        input  imem_busy_o, imem_rdy_o, imem_rd_data_o,
        output dmem_rd_en_i, dmem_wr_en_i, dmem_addr_i, dmem_wr_size_i, dmem_wr_data_i,
        input  dmem_busy_o, dmem_rdy_o, dmem_rd_data_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_size_o, mem_wr_data_o,
        output mem_busy_i, mem_rdy_i, mem_rd_data_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one op in flight,
// dmem favoured but imem forced through after STARVE_LIMIT consecutive dmem wins.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IMEM, OWN_DMEM} owner_t;

    state_t              r_state, w_next;
    owner_t              r_owner;
    logic [CNT_W-1:0]    r_starve_cnt;

    logic                r_imem_valid;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic                r_dmem_valid;
    logic                r_dmem_we;
    logic [ADDR_W-1:0]   r_dmem_addr;
    logic [1:0]          r_dmem_size;
    logic [31:0]         r_dmem_wr_data;

    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [1:0]          r_mem_size;
    logic [31:0]         r_mem_wr_data;
    logic [31:0]         r_imem_rd_data;
    logic [31:0]         r_dmem_rd_data;

    logic                w_imem_cap, w_dmem_cap, w_imem_pend, w_dmem_pend;
    logic                w_grant, w_grant_imem, w_imem_done, w_dmem_done;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [1:0]          w_mem_size;
    logic [31:0]         w_mem_wr_data;

    // A pulse arriving in IDLE is visible to arbitration on the same edge it is captured.
    assign w_imem_cap  = bus.imem_rd_en_i & ~r_imem_valid;
    assign w_dmem_cap  = (bus.dmem_rd_en_i | bus.dmem_wr_en_i) & ~r_dmem_valid;
    assign w_imem_pend = r_imem_valid | w_imem_cap;
    assign w_dmem_pend = r_dmem_valid | w_dmem_cap;
    assign w_imem_done = (r_state == S_WAIT) & bus.mem_rdy_i & (r_owner == OWN_IMEM);
    assign w_dmem_done = (r_state == S_WAIT) & bus.mem_rdy_i & (r_owner == OWN_DMEM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_grant      = 1'b0;
        w_grant_imem = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((w_imem_pend | w_dmem_pend) & ~bus.mem_busy_i) begin
                    w_grant      = 1'b1;
                    w_grant_imem = w_imem_pend &
                                   (~w_dmem_pend | (r_starve_cnt == CNT_W'(STARVE_LIMIT)));
                    w_next       = S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (bus.mem_rdy_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Winner's request fields, taken from the slot or straight from a same-cycle pulse.
    always_comb begin
        w_mem_we      = r_dmem_valid ? r_dmem_we      : bus.dmem_wr_en_i;
        w_mem_addr    = r_dmem_valid ? r_dmem_addr    : bus.dmem_addr_i;
        w_mem_size    = r_dmem_valid ? r_dmem_size    : bus.dmem_wr_size_i;
        w_mem_wr_data = r_dmem_valid ? r_dmem_wr_data : bus.dmem_wr_data_i;
        if (w_grant_imem) begin
            w_mem_we      = 1'b0;
            w_mem_addr    = r_imem_valid ? r_imem_addr : bus.imem_addr_i;
            w_mem_size    = 2'd2;
            w_mem_wr_data = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_imem_valid   <= 1'b0;
            r_imem_addr    <= '0;
            r_dmem_valid   <= 1'b0;
            r_dmem_we      <= 1'b0;
            r_dmem_addr    <= '0;
            r_dmem_size    <= 2'd0;
            r_dmem_wr_data <= 32'd0;
        end else begin
            if (w_imem_done) r_imem_valid <= 1'b0;
            if (w_imem_cap) begin
                r_imem_valid <= 1'b1;
                r_imem_addr  <= bus.imem_addr_i;
            end
            if (w_dmem_done) r_dmem_valid <= 1'b0;
            if (w_dmem_cap) begin
                r_dmem_valid   <= 1'b1;
                r_dmem_we      <= bus.dmem_wr_en_i;
                r_dmem_addr    <= bus.dmem_addr_i;
                r_dmem_size    <= bus.dmem_wr_size_i;
                r_dmem_wr_data <= bus.dmem_wr_data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner        <= OWN_NONE;
            r_starve_cnt   <= '0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_size     <= 2'd0;
            r_mem_wr_data  <= 32'd0;
            r_imem_rd_data <= 32'd0;
            r_dmem_rd_data <= 32'd0;
        end else begin
            if (w_grant) begin
                r_owner       <= w_grant_imem ? OWN_IMEM : OWN_DMEM;
                r_mem_we      <= w_mem_we;
                r_mem_addr    <= w_mem_addr;
                r_mem_size    <= w_mem_size;
                r_mem_wr_data <= w_mem_wr_data;
                if (w_grant_imem | ~w_imem_pend)
                    r_starve_cnt <= '0;
                else if (r_starve_cnt != CNT_W'(STARVE_LIMIT))
                    r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end else if (w_imem_done | w_dmem_done) begin
                r_owner <= OWN_NONE;
            end
            if (w_imem_done) r_imem_rd_data <= bus.mem_rd_data_i;
            if (w_dmem_done) r_dmem_rd_data <= bus.mem_rd_data_i;
        end
    end

    assign bus.imem_busy_o    = r_imem_valid;
    assign bus.imem_rdy_o     = w_imem_done;
    assign bus.imem_rd_data_o = w_imem_done ? bus.mem_rd_data_i : r_imem_rd_data;
    assign bus.dmem_busy_o    = r_dmem_valid;
    assign bus.dmem_rdy_o     = w_dmem_done;
    assign bus.dmem_rd_data_o = w_dmem_done ? bus.mem_rd_data_i : r_dmem_rd_data;
    assign bus.mem_req_o      = (r_state == S_ISSUE);
    assign bus.mem_we_o       = r_mem_we;
    assign bus.mem_addr_o     = r_mem_addr;
    assign bus.mem_size_o     = r_mem_size;
    assign bus.mem_wr_data_o  = r_mem_wr_data;

    // Requesters must not pulse while their slot is occupied.
    a_imem_no_pulse_busy: assert property (@(posedge clk) disable iff (rst)
        !(bus.imem_rd_en_i && r_imem_valid))
        else $error("imem request pulsed while busy");
    a_dmem_no_pulse_busy: assert property (@(posedge clk) disable iff (rst)
        !((bus.dmem_rd_en_i || bus.dmem_wr_en_i) && r_dmem_valid))
        else $error("dmem request pulsed while busy");
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, starvation, write, memory backpressure, reset.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_W = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are changed here, outputs checked 1ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst = 1'b1;
        bus.imem_rd_en_i   = 1'b0;
        bus.imem_addr_i    = '0;
        bus.dmem_rd_en_i   = 1'b0;
        bus.dmem_wr_en_i   = 1'b0;
        bus.dmem_addr_i    = '0;
        bus.dmem_wr_size_i = 2'd0;
        bus.dmem_wr_data_i = 32'd0;
        bus.mem_busy_i     = 1'b0;
        bus.mem_rdy_i      = 1'b0;
        bus.mem_rd_data_i  = 32'd0;

        // Reset state
        cyc(); cyc();
        chk("rst_mem_req",   32'(bus.mem_req_o), 32'd0);
        chk("rst_imem_busy", 32'(bus.imem_busy_o), 32'd0);
        chk("rst_dmem_busy", 32'(bus.dmem_busy_o), 32'd0);
        chk("rst_mem_addr",  bus.mem_addr_o, 32'd0);
        chk("rst_imem_data", bus.imem_rd_data_o, 32'd0);
        rst = 1'b0;
        cyc();

        // Single fetch at 0x100, completion 3 cycles after the request
        bus.imem_rd_en_i = 1'b1;
        bus.imem_addr_i  = 32'h100;
        settle();
        chk("f1_no_req_same_cycle", 32'(bus.mem_req_o), 32'd0);
        cyc();
        bus.imem_rd_en_i = 1'b0;
        bus.imem_addr_i  = 32'h0;
        settle();
        chk("f1_req",       32'(bus.mem_req_o), 32'd1);
        chk("f1_req_addr",  bus.mem_addr_o, 32'h100);
        chk("f1_req_we",    32'(bus.mem_we_o), 32'd0);
        chk("f1_imem_busy", 32'(bus.imem_busy_o), 32'd1);
        cyc();
        chk("f1_req_single", 32'(bus.mem_req_o), 32'd0);
        cyc(); cyc();
        bus.mem_rdy_i     = 1'b1;
        bus.mem_rd_data_i = 32'hCAFE0001;
        settle();
        chk("f1_imem_rdy",  32'(bus.imem_rdy_o), 32'd1);
        chk("f1_imem_data", bus.imem_rd_data_o, 32'hCAFE0001);
        chk("f1_dmem_rdy",  32'(bus.dmem_rdy_o), 32'd0);
        chk("f1_busy_thru_rdy", 32'(bus.imem_busy_o), 32'd1);
        cyc();
        bus.mem_rdy_i     = 1'b0;
        bus.mem_rd_data_i = 32'h55555555;
        settle();
        chk("f1_rdy_drop",  32'(bus.imem_rdy_o), 32'd0);
        chk("f1_busy_clr",  32'(bus.imem_busy_o), 32'd0);
        chk("f1_data_hold", bus.imem_rd_data_o, 32'hCAFE0001);

        // imem and dmem pulse together: dmem first, imem after dmem completes
        bus.imem_rd_en_i = 1'b1;
        bus.imem_addr_i  = 32'h200;
        bus.dmem_rd_en_i = 1'b1;
        bus.dmem_addr_i  = 32'h300;
        cyc();
        bus.imem_rd_en_i = 1'b0;
        bus.dmem_rd_en_i = 1'b0;
        settle();
        chk("c_req_dmem",  32'(bus.mem_req_o), 32'd1);
        chk("c_addr_dmem", bus.mem_addr_o, 32'h300);
        chk("c_imem_busy", 32'(bus.imem_busy_o), 32'd1);
        cyc();
        bus.mem_rdy_i     = 1'b1;
        bus.mem_rd_data_i = 32'h00000011;
        settle();
        chk("c_dmem_rdy",  32'(bus.dmem_rdy_o), 32'd1);
        chk("c_dmem_data", bus.dmem_rd_data_o, 32'h11);
        chk("c_imem_rdy0", 32'(bus.imem_rdy_o), 32'd0);
        cyc();
        bus.mem_rdy_i = 1'b0;
        settle();
        chk("c_gap_no_req",   32'(bus.mem_req_o), 32'd0);
        chk("c_dmem_busy0",   32'(bus.dmem_busy_o), 32'd0);
        cyc();
        chk("c_req_imem",  32'(bus.mem_req_o), 32'd1);
        chk("c_addr_imem", bus.mem_addr_o, 32'h200);
        cyc();
        bus.mem_rdy_i     = 1'b1;
        bus.mem_rd_data_i = 32'h00000022;
        settle();
        chk("c_imem_rdy",  32'(bus.imem_rdy_o), 32'd1);
        chk("c_imem_data", bus.imem_rd_data_o, 32'h22);
        chk("c_dmem_hold", bus.dmem_rd_data_o, 32'h11);
        cyc();
        bus.mem_rdy_i = 1'b0;

        // Starvation: imem waits behind four dmem grants, then is forced through
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
                bus.imem_rd_en_i = 1'b1;
                bus.imem_addr_i  = 32'h500;
            end
            bus.dmem_rd_en_i = 1'b1;
            bus.dmem_addr_i  = 32'h1000 + 32'(4 * k);
            cyc();
            bus.imem_rd_en_i = 1'b0;
            bus.dmem_rd_en_i = 1'b0;
            settle();
            chk("s_dmem_addr", bus.mem_addr_o, 32'h1000 + 32'(4 * k));
            cyc();
            bus.mem_rdy_i     = 1'b1;
            bus.mem_rd_data_i = 32'hD0 + 32'(k);
            settle();
            chk("s_dmem_rdy", 32'(bus.dmem_rdy_o), 32'd1);
            cyc();
            bus.mem_rdy_i = 1'b0;
        end
        bus.dmem_rd_en_i = 1'b1;
        bus.dmem_addr_i  = 32'h1010;
        cyc();
        bus.dmem_rd_en_i = 1'b0;
        settle();
        chk("s_forced_req",  32'(bus.mem_req_o), 32'd1);
        chk("s_forced_imem", bus.mem_addr_o, 32'h500);
        cyc();
        bus.mem_rdy_i     = 1'b1;
        bus.mem_rd_data_i = 32'h00000E50;
        settle();
        chk("s_imem_rdy", 32'(bus.imem_rdy_o), 32'd1);
        chk("s_dmem_rdy0", 32'(bus.dmem_rdy_o), 32'd0);
        cyc();
        bus.mem_rdy_i = 1'b0;
        cyc();
        chk("s_dmem_after", bus.mem_addr_o, 32'h1010);
        chk("s_dmem_after_req", 32'(bus.mem_req_o), 32'd1);
        cyc();
        bus.mem_rdy_i = 1'b1;
        cyc();
        bus.mem_rdy_i = 1'b0;

        // Word write with rd_en also asserted: write wins
        bus.dmem_wr_en_i   = 1'b1;
        bus.dmem_rd_en_i   = 1'b1;
        bus.dmem_addr_i    = 32'h40;
        bus.dmem_wr_size_i = 2'd2;
        bus.dmem_wr_data_i = 32'hDEADBEEF;
        cyc();
        bus.dmem_wr_en_i   = 1'b0;
        bus.dmem_rd_en_i   = 1'b0;
        bus.dmem_wr_data_i = 32'h0;
        settle();
        chk("w_req",  32'(bus.mem_req_o), 32'd1);
        chk("w_we",   32'(bus.mem_we_o), 32'd1);
        chk("w_size", 32'(bus.mem_size_o), 32'd2);
        chk("w_addr", bus.mem_addr_o, 32'h40);
        chk("w_data", bus.mem_wr_data_o, 32'hDEADBEEF);
        cyc(); cyc();
        chk("w_no_rdy_early", 32'(bus.dmem_rdy_o), 32'd0);
        bus.mem_rdy_i = 1'b1;
        settle();
        chk("w_dmem_rdy", 32'(bus.dmem_rdy_o), 32'd1);
        chk("w_imem_rdy", 32'(bus.imem_rdy_o), 32'd0);
        cyc();
        bus.mem_rdy_i = 1'b0;
        settle();
        chk("w_rdy_drop",   32'(bus.dmem_rdy_o), 32'd0);
        chk("w_busy_clear", 32'(bus.dmem_busy_o), 32'd0);

        // Memory backpressure: busy for 5 cycles, issue the cycle after it falls
        bus.mem_busy_i   = 1'b1;
        bus.dmem_rd_en_i = 1'b1;
        bus.dmem_addr_i  = 32'h80;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("b_hold_no_req", 32'(bus.mem_req_o), 32'd0);
            cyc();
            bus.dmem_rd_en_i = 1'b0;
        end
        bus.mem_busy_i = 1'b0;
        settle();
        chk("b_fall_no_req", 32'(bus.mem_req_o), 32'd0);
        chk("b_dmem_busy",   32'(bus.dmem_busy_o), 32'd1);
        cyc();
        chk("b_req",  32'(bus.mem_req_o), 32'd1);
        chk("b_addr", bus.mem_addr_o, 32'h80);
        cyc();
        bus.mem_rdy_i     = 1'b1;
        bus.mem_rd_data_i = 32'h00000088;
        settle();
        chk("b_dmem_data", bus.dmem_rd_data_o, 32'h88);
        cyc();
        bus.mem_rdy_i = 1'b0;

        // Reset while waiting on memory; the stale completion must be ignored
        bus.imem_rd_en_i = 1'b1;
        bus.imem_addr_i  = 32'h600;
        cyc();
        bus.imem_rd_en_i = 1'b0;
        settle();
        chk("r_req", 32'(bus.mem_req_o), 32'd1);
        cyc();
        rst = 1'b1;
        settle();
        chk("r_busy_clr", 32'(bus.imem_busy_o), 32'd0);
        chk("r_addr_clr", bus.mem_addr_o, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        bus.mem_rdy_i     = 1'b1;
        bus.mem_rd_data_i = 32'h0BADBAD0;
        settle();
        chk("r_stale_imem_rdy", 32'(bus.imem_rdy_o), 32'd0);
        chk("r_stale_dmem_rdy", 32'(bus.dmem_rdy_o), 32'd0);
        chk("r_stale_data",     bus.imem_rd_data_o, 32'd0);
        cyc();
        bus.mem_rdy_i = 1'b0;
        settle();
        chk("r_no_req", 32'(bus.mem_req_o), 32'd0);
        bus.dmem_rd_en_i = 1'b1;
        bus.dmem_addr_i  = 32'h700;
        cyc();
        bus.dmem_rd_en_i = 1'b0;
        settle();
        chk("r_new_req",  32'(bus.mem_req_o), 32'd1);
        chk("r_new_addr", bus.mem_addr_o, 32'h700);
        cyc();
        bus.mem_rdy_i     = 1'b1;
        bus.mem_rd_data_i = 32'h00000077;
        settle();
        chk("r_new_rdy",  32'(bus.dmem_rdy_o), 32'd1);
        chk("r_new_data", bus.dmem_rd_data_o, 32'h77);
        cyc();
        bus.mem_rdy_i = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
